subpel_sequencer: RTL and testbench

SUBPEL_SEQUENCER -- requirements
Module: subpel_sequencer

---
 rtl/subpel_sequencer_if.sv | 32 +++
 rtl/subpel_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_subpel_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subpel_sequencer_if.sv
// Control/handshake bundle between the sub-pel sequencer and its surroundings.
//   slave  : the sequencer (consumes start/frac/abort/row_valid, drives the rest)
//   master : the block requester / datapath side
interface subpel_sequencer_if;
    logic       start;
    logic [1:0] frac_x;
    logic [1:0] frac_y;
    logic       abort;
    logic       row_valid;
    logic       row_ready;
    logic       load_in;
    logic [7:0] sel;
    logic       load_L;
    logic       out_we;
    logic [4:0] out_idx;
    logic [1:0] frac_x_q;
    logic [1:0] frac_y_q;
    logic       busy;
    logic       done;

    modport slave (
        input  start, frac_x, frac_y, abort, row_valid,
        output row_ready, load_in, sel, load_L, out_we, out_idx,
               frac_x_q, frac_y_q, busy, done
    );

    modport master (
        output start, frac_x, frac_y, abort, row_valid,
        input  row_ready, load_in, sel, load_L, out_we, out_idx,
               frac_x_q, frac_y_q, busy, done
    );
endinterface

// File: rtl/subpel_sequencer.sv
// Sub-pixel interpolation sequencer: loads ROWS window rows, steps the input
// mux through a horizontal pass (ROWS steps) and an optional vertical pass
// (NUM_PIXEL steps), and emits FIR_LAT-delayed load/write strobes.
// Ports: clk, rst_n (async active-low), bus (subpel_sequencer_if.slave):
//   start/frac_x/frac_y/abort/row_valid in; row_ready, load_in, sel, load_L,
//   out_we, out_idx, frac_x_q, frac_y_q, busy, done out.
module subpel_sequencer #(
    parameter int unsigned NUM_PIXEL = 8,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned FIR_LAT   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    subpel_sequencer_if.slave  bus
);
    localparam int unsigned ROWS  = NUM_PIXEL + TAPS - 1;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned SEL_W = 8;

    localparam logic [CNT_W-1:0] ROWS_M1 = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] NP_M1   = CNT_W'(NUM_PIXEL - 1);
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(FIR_LAT - 1);
    // HPASS steps whose result is also a final output pixel (first-pass column)
    localparam logic [CNT_W-1:0] OUT_LO  = CNT_W'(3);
    localparam logic [CNT_W-1:0] OUT_HI  = CNT_W'(3 + NUM_PIXEL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_HPASS, S_VPASS, S_DRAIN, S_DONE
    } state_t;

    typedef struct packed {
        logic             load;
        logic             we;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fx_q, fx_d;
    logic [1:0]       fy_q, fy_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             row_ready_q, row_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    tag_t             pipe_q [FIR_LAT];
    tag_t             pipe_d [FIR_LAT];

    logic             handshake;
    logic             abort_hit;
    tag_t             issue;

    assign handshake = bus.row_valid & row_ready_q;
    assign abort_hit = bus.abort & (state_q != S_IDLE);

    // Next state, counters, issue tag and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        issue   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    fx_d    = bus.frac_x;
                    fy_d    = bus.frac_y;
                end
            end
            S_FILL: begin
                if (handshake) begin
                    if (cnt_q == ROWS_M1) begin
                        state_d = S_HPASS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HPASS: begin
                issue.load = 1'b1;
                if (cnt_q >= OUT_LO && cnt_q <= OUT_HI) begin
                    issue.we  = 1'b1;
                    issue.idx = cnt_q - OUT_LO;
                end
                if (cnt_q == ROWS_M1) begin
                    state_d = (fy_q != 2'd0) ? S_VPASS : S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VPASS: begin
                issue.we  = 1'b1;
                issue.idx = IDX_W'(NUM_PIXEL) + cnt_q;
                if (cnt_q == NP_M1) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAT_M1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort drops the block and anything still in flight
        if (abort_hit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            issue   = '0;
        end

        pipe_d[0] = issue;
        for (int i = 1; i < int'(FIR_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (abort_hit) begin
            for (int i = 0; i < int'(FIR_LAT); i++) begin
                pipe_d[i] = '0;
            end
        end

        // Outputs are registered: decode them from the next state
        sel_d = '0;
        case (state_d)
            S_HPASS: sel_d = SEL_W'(cnt_d);
            S_VPASS: sel_d = SEL_W'(ROWS) + SEL_W'(cnt_d);
            default: sel_d = '0;
        endcase
        row_ready_d = (state_d == S_FILL);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            sel_q       <= '0;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < int'(FIR_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            sel_q       <= sel_d;
            row_ready_q <= row_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < int'(FIR_LAT); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.row_ready = row_ready_q;
    assign bus.load_in   = handshake;
    assign bus.sel       = sel_q;
    assign bus.load_L    = pipe_q[FIR_LAT-1].load;
    assign bus.out_we    = pipe_q[FIR_LAT-1].we;
    assign bus.out_idx   = pipe_q[FIR_LAT-1].idx;
    assign bus.frac_x_q  = fx_q;
    assign bus.frac_y_q  = fy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_subpel_sequencer.sv
// Self-checking bench for subpel_sequencer: a table of single-cycle vectors,
// directed multi-cycle block scenarios, and randomized traffic, all compared
// every cycle against an offset-arithmetic reference model.
module tb_subpel_sequencer;
    localparam int NP   = 8;
    localparam int TAPS = 8;
    localparam int LAT  = 2;
    localparam int ROWS = NP + TAPS - 1;

    typedef struct packed {
        logic       rr;
        logic       li;
        logic [7:0] sel;
        logic       ll;
        logic       we;
        logic [4:0] idx;
        logic [1:0] fxq;
        logic [1:0] fyq;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        logic       start;
        logic [1:0] fx;
        logic [1:0] fy;
        logic       abort;
        logic       rv;
        logic       e_rr;
        logic       e_li;
        logic       e_busy;
        logic [1:0] e_fxq;
        logic [1:0] e_fyq;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    subpel_sequencer_if bus();

    subpel_sequencer #(.NUM_PIXEL(NP), .TAPS(TAPS), .FIR_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 fill (rows counted), 2 run (offset r
    // from the first HPASS cycle; everything else is arithmetic on r).
    int         m_ph, m_cnt, m_r;
    logic [1:0] m_fx, m_fy;

    // Scenario monitors
    int mon_we, mon_ll, mon_li, mon_done, mon_done_t;
    int mon_last_li_t, mon_first_run_t, mon_quiet_bad;
    int mon_idx[$];

    function automatic void model_reset();
        m_ph = 0; m_cnt = 0; m_r = 0; m_fx = 2'd0; m_fy = 2'd0;
    endfunction

    function automatic out_t model_out(input logic rv);
        out_t o;
        int   h, v, j;
        o     = '0;
        o.fxq = m_fx;
        o.fyq = m_fy;
        h     = ROWS;
        v     = (m_fy != 2'd0) ? NP : 0;
        if (m_ph == 1) begin
            o.rr = 1'b1; o.li = rv; o.busy = 1'b1;
        end else if (m_ph == 2) begin
            o.busy = 1'b1;
            if (m_r < h)          o.sel = 8'(m_r);
            else if (m_r < h + v) o.sel = 8'(ROWS + m_r - h);
            j = m_r - LAT;
            if (j >= 0 && j < h) o.ll = 1'b1;
            if (j >= 3 && j < 3 + NP) begin
                o.we = 1'b1; o.idx = 5'(j - 3);
            end else if (j >= h && j < h + v) begin
                o.we = 1'b1; o.idx = 5'(NP + j - h);
            end
            o.done = (m_r == h + v + LAT);
        end
        return o;
    endfunction

    function automatic void model_update(input logic start, input logic [1:0] fx,
                                         input logic [1:0] fy, input logic abort,
                                         input logic rv);
        if (m_ph != 0 && abort) begin
            m_ph = 0;
            return;
        end
        case (m_ph)
            0: if (start) begin
                m_ph = 1; m_cnt = 0; m_fx = fx; m_fy = fy;
            end
            1: if (rv) begin
                m_cnt++;
                if (m_cnt == ROWS) begin m_ph = 2; m_r = 0; end
            end
            default: begin
                if (m_r == ROWS + ((m_fy != 2'd0) ? NP : 0) + LAT) m_ph = 0;
                else m_r++;
            end
        endcase
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.rr   = bus.row_ready;
        o.li   = bus.load_in;
        o.sel  = bus.sel;
        o.ll   = bus.load_L;
        o.we   = bus.out_we;
        o.idx  = bus.out_idx;
        o.fxq  = bus.frac_x_q;
        o.fyq  = bus.frac_y_q;
        o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got rr=%b li=%b sel=%0d ll=%b we=%b idx=%0d fx=%0d fy=%0d busy=%b done=%b expected rr=%b li=%b sel=%0d ll=%b we=%b idx=%0d fx=%0d fy=%0d busy=%b done=%b",
                     name, $time, act.rr, act.li, act.sel, act.ll, act.we, act.idx,
                     act.fxq, act.fyq, act.busy, act.done, exp.rr, exp.li, exp.sel,
                     exp.ll, exp.we, exp.idx, exp.fxq, exp.fyq, exp.busy, exp.done);
        end
    endtask

    // One clock cycle: compare on the falling edge, advance model on the rising edge
    task automatic step(output out_t obs);
        @(negedge clk);
        obs = dut_out();
        chk_vec("cycle", obs, model_out(bus.row_valid));
        @(posedge clk);
        model_update(bus.start, bus.frac_x, bus.frac_y, bus.abort, bus.row_valid);
        #1;
    endtask

    function automatic int idx_order_err();
        foreach (mon_idx[i]) if (mon_idx[i] != i) return i;
        return -1;
    endfunction

    // Directed block: start at t=0; rv_mode 0 = held high, 1 = toggling.
    // Activity of any kind after quiet_t is counted as a violation.
    task automatic run_seq(input logic [1:0] fx, input logic [1:0] fy, input int rv_mode,
                           input int abort_at, input logic extra_starts, input int rst_at,
                           input int quiet_t, input int ncyc);
        out_t obs;
        mon_we = 0; mon_ll = 0; mon_li = 0; mon_done = 0; mon_done_t = -1;
        mon_last_li_t = -1; mon_first_run_t = -1; mon_quiet_bad = 0;
        mon_idx.delete();
        for (int t = 0; t < ncyc; t++) begin
            bus.start     = (t == 0) || (extra_starts && (t == 20 || t == 41));
            bus.frac_x    = (t == 0) ? fx : ~fx;
            bus.frac_y    = (t == 0) ? fy : ~fy;
            bus.abort     = (t == abort_at);
            bus.row_valid = (rv_mode == 0) ? 1'b1 : 1'(t % 2);
            if (t == rst_at) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_vec("async_reset", dut_out(), '0);
            end
            if (rst_at >= 0 && t == rst_at + 3) rst_n = 1'b1;
            step(obs);
            if (obs.we) begin mon_we++; mon_idx.push_back(int'(obs.idx)); end
            if (obs.ll) mon_ll++;
            if (obs.li) begin mon_li++; mon_last_li_t = t; end
            if (obs.done) begin mon_done++; mon_done_t = t; end
            if (obs.busy && !obs.rr && mon_first_run_t < 0) mon_first_run_t = t;
            if (t > quiet_t && (obs.busy || obs.we || obs.ll || obs.done || obs.rr))
                mon_quiet_bad++;
        end
    endtask

    vec_t vecs[8];
    out_t obs;

    initial begin
        bus.start = 1'b1; bus.frac_x = 2'd3; bus.frac_y = 2'd3;
        bus.abort = 1'b0; bus.row_valid = 1'b1;
        rst_n = 1'b0;
        model_reset();

        // Reset state with start and row_valid active
        @(negedge clk);
        chk_vec("reset_state", dut_out(), '0);
        @(posedge clk);
        @(negedge clk);
        chk_vec("reset_hold", dut_out(), '0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst_n = 1'b1;

        //            start fx fy abort rv  rr li busy fxq fyq
        vecs[0] = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1] = '{1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[2] = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2};
        vecs[3] = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2};
        vecs[4] = '{1'b1, 2'd3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2};
        vecs[5] = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2};
        vecs[6] = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2};
        vecs[7] = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2};
        for (int i = 0; i < 8; i++) begin
            bus.start = vecs[i].start; bus.frac_x = vecs[i].fx; bus.frac_y = vecs[i].fy;
            bus.abort = vecs[i].abort; bus.row_valid = vecs[i].rv;
            step(obs);
            chk($sformatf("vec%0d_row_ready", i), int'(obs.rr), int'(vecs[i].e_rr));
            chk($sformatf("vec%0d_load_in", i), int'(obs.li), int'(vecs[i].e_li));
            chk($sformatf("vec%0d_busy", i), int'(obs.busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_frac", i), int'({obs.fxq, obs.fyq}),
                int'({vecs[i].e_fxq, vecs[i].e_fyq}));
        end

        // Full block with vertical pass
        run_seq(2'd1, 2'd2, 0, -1, 1'b0, -1, 41, 50);
        chk("full_done_t", mon_done_t, 41);
        chk("full_done_n", mon_done, 1);
        chk("full_hpass_t", mon_first_run_t, 16);
        chk("full_we_n", mon_we, 16);
        chk("full_idx_order", idx_order_err(), -1);
        chk("full_loadL_n", mon_ll, 15);
        chk("full_quiet", mon_quiet_bad, 0);

        // Vertical pass skipped
        run_seq(2'd2, 2'd0, 0, -1, 1'b0, -1, 33, 42);
        chk("novp_done_t", mon_done_t, 33);
        chk("novp_we_n", mon_we, 8);
        chk("novp_idx_order", idx_order_err(), -1);
        chk("novp_loadL_n", mon_ll, 15);
        chk("novp_quiet", mon_quiet_bad, 0);

        // Stalling row_valid during FILL
        run_seq(2'd3, 2'd1, 1, -1, 1'b0, -1, 55, 64);
        chk("stall_load_in_n", mon_li, 15);
        chk("stall_hpass_after_last_row", mon_first_run_t, mon_last_li_t + 1);
        chk("stall_done_t", mon_done_t, 55);

        // Abort in VPASS step 4, then a clean block
        run_seq(2'd1, 2'd3, 0, 35, 1'b0, -1, 35, 50);
        chk("abort_done_n", mon_done, 0);
        chk("abort_quiet", mon_quiet_bad, 0);
        run_seq(2'd1, 2'd3, 0, -1, 1'b0, -1, 41, 50);
        chk("post_abort_done_t", mon_done_t, 41);
        chk("post_abort_we_n", mon_we, 16);

        // Starts in HPASS and DONE are ignored
        run_seq(2'd2, 2'd1, 0, -1, 1'b1, -1, 41, 55);
        chk("extra_start_done_n", mon_done, 1);
        chk("extra_start_quiet", mon_quiet_bad, 0);

        // Reset in HPASS, released three cycles later, then a normal block
        run_seq(2'd1, 2'd2, 0, -1, 1'b0, 20, 19, 30);
        chk("rst_done_n", mon_done, 0);
        chk("rst_quiet", mon_quiet_bad, 0);
        run_seq(2'd1, 2'd2, 0, -1, 1'b0, -1, 41, 50);
        chk("post_rst_done_t", mon_done_t, 41);
        chk("post_rst_we_n", mon_we, 16);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.frac_x    = 2'($urandom_range(0, 3));
            bus.frac_y    = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            bus.abort     = ($urandom_range(0, 149) == 0);
            bus.row_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_vec("rand_reset", dut_out(), model_out(bus.row_valid));
                step(obs);
                rst_n = 1'b1;
            end else begin
                step(obs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
